// File: rtl/regfile_mp.sv
// Multi-port integer register file for the pipelined core.
//  - NRD combinational read ports with same-cycle write-to-read bypass
//  - two write ports; port 1 wins when both hit the same register
//  - per-register busy scoreboard (issue sets, writeback clears)
//  - registered write-collision pulse
// Register 0 is hardwired to zero and is never busy.
// Optional build macro REGFILE_TEST_INIT_EN: reset loads x1..x7 with their own index.
module regfile_mp #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [1:0]          we,
  input  logic [2*AW-1:0]     wa,
  input  logic [2*XLEN-1:0]   wd,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic [NREGS-1:0]    busy_vec,
  output logic                wr_collide
);

  // Highest register index given a non-zero reset value.
`ifdef REGFILE_TEST_INIT_EN
  localparam int unsigned InitMax = 7;
`else
  localparam int unsigned InitMax = 0;
`endif

  function automatic logic [XLEN-1:0] reset_val(input int unsigned idx);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx >= 1 && idx <= InitMax) begin
      v = XLEN'(idx);
    end
    return v;
  endfunction

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             collide_q, collide_d;

  logic [AW-1:0]    wa_a [2];
  logic [XLEN-1:0]  wd_a [2];
  logic [1:0]       wr_hit;  // enabled write to a nonzero register
  logic [AW-1:0]    ra_a [NRD];

  // Unpack write ports and qualify enables against register 0.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      wa_a[j]   = wa[j*AW +: AW];
      wd_a[j]   = wd[j*XLEN +: XLEN];
      wr_hit[j] = we[j] && (wa_a[j] != '0);
    end
  end

  // Unpack read addresses.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      ra_a[k] = rd_addr[k*AW +: AW];
    end
  end

  // Register array next state; port 1 applied last so it wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < 2; j++) begin
      if (wr_hit[j]) begin
        regs_d[wa_a[j]] = wd_a[j];
      end
    end
    regs_d[0] = '0;
  end

  // Collision flag: both ports commit to the same nonzero register.
  always_comb begin
    collide_d = (&wr_hit) && (wa_a[0] == wa_a[1]);
  end

  // Scoreboard next state; a new issue supersedes a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (issue_valid && (issue_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((wr_hit[0] && (wa_a[0] == AW'(r))) ||
                   (wr_hit[1] && (wa_a[1] == AW'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= reset_val(i);
      end
      busy_q    <= '0;
      collide_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      collide_q <= collide_d;
    end
  end

  // Read ports: x0 -> 0, then write port 1 bypass, then port 0 bypass, then array.
  always_comb begin
    logic byp0, byp1;
    byp0    = 1'b0;
    byp1    = 1'b0;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      byp1 = we[1] && (wa_a[1] == ra_a[k]);
      byp0 = we[0] && (wa_a[0] == ra_a[k]);
      if (ra_a[k] == '0) begin
        rd_data[k*XLEN +: XLEN] = '0;
      end else if (byp1) begin
        rd_data[k*XLEN +: XLEN] = wd_a[1];
      end else if (byp0) begin
        rd_data[k*XLEN +: XLEN] = wd_a[0];
      end else begin
        rd_data[k*XLEN +: XLEN] = regs_q[ra_a[k]];
      end
      // Bypassed data is already valid, so the port is not stalled.
      rd_busy[k] = busy_q[ra_a[k]] && !(byp0 || byp1);
    end
  end

  assign busy_vec   = busy_q;
  assign wr_collide = collide_q;

`ifndef SYNTHESIS
  // Trace committed writes; port 0 is dropped when it collides with port 1.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wr_hit[0] && !collide_d) begin
        $display("regfile_mp: write x%0d <= %h", wa_a[0], wd_a[0]);
      end
      if (wr_hit[1]) begin
        $display("regfile_mp: write x%0d <= %h", wa_a[1], wd_a[1]);
      end
    end
  end

  // Register 0 never becomes busy.
  a_x0_idle : assert property (@(posedge clk) disable iff (!rst_n) !busy_q[0]);
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp with an array-based reference model.
module tb_regfile_mp;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [1:0]          we;
  logic [2*AW-1:0]     wa;
  logic [2*XLEN-1:0]   wd;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic [NREGS-1:0]    busy_vec;
  logic                wr_collide;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy_vec    (busy_vec),
    .wr_collide  (wr_collide)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [XLEN-1:0] m_mem  [NREGS];
  logic            m_busy [NREGS];
  logic            m_coll;

  function automatic logic [XLEN-1:0] init_val(input int i);
`ifdef REGFILE_TEST_INIT_EN
    if (i >= 1 && i <= 7) return XLEN'(i);
`endif
    return '0;
  endfunction

  function automatic logic [XLEN-1:0] rdp(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  function automatic logic [NREGS-1:0] m_busy_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Expected read value under the current bus inputs.
  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we[1] && wa[AW +: AW] == a) return wd[XLEN +: XLEN];
    if (we[0] && wa[0 +: AW] == a) return wd[0 +: XLEN];
    return m_mem[a];
  endfunction

  function automatic logic m_rbusy(input logic [AW-1:0] a);
    logic wr;
    wr = (we[1] && wa[AW +: AW] == a) || (we[0] && wa[0 +: AW] == a);
    return (a != 0) && m_busy[a] && !wr;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = init_val(i);
      m_busy[i] = 1'b0;
    end
    m_coll = 1'b0;
  endtask

  // Advance one clock: update model from current inputs, then pass the edge.
  task automatic tick();
    logic [AW-1:0] a0, a1;
    a0 = wa[0 +: AW];
    a1 = wa[AW +: AW];
    if (rst_n) begin
      m_coll = (we == 2'b11) && (a0 == a1) && (a0 != 0);
      if (we[0] && a0 != 0) m_busy[a0] = 1'b0;
      if (we[1] && a1 != 0) m_busy[a1] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (we[0] && a0 != 0) m_mem[a0] = wd[0 +: XLEN];
      if (we[1] && a1 != 0) m_mem[a1] = wd[XLEN +: XLEN];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we          = 2'b00;
    wa          = '0;
    wd          = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic drive_wr(input logic [1:0] e, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                          input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
    we = e;
    wa = {a1, a0};
    wd = {d1, d0};
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] e3, e7;
    e3 = init_val(3);
    e7 = init_val(7);
    rst_n = 1'b0;
    idle();
    rd_addr = '0;
    model_reset();
    set_rd(0, 5'd3);
    set_rd(1, 5'd7);
    #3;
    checks++;
    if (busy_vec !== '0) begin
      errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec);
    end
    checks++;
    if (wr_collide !== 1'b0) begin
      errors++; $display("FAIL reset_collide: got %b expected 0", wr_collide);
    end
    checks++;
    if (rdp(0) !== e3) begin
      errors++; $display("FAIL reset_x3: got %h expected %h", rdp(0), e3);
    end
    checks++;
    if (rdp(1) !== e7) begin
      errors++; $display("FAIL reset_x7: got %h expected %h", rdp(1), e7);
    end
    set_rd(0, 5'd8);
    #1;
    checks++;
    if (rdp(0) !== '0) begin
      errors++; $display("FAIL reset_x8: got %h expected 0", rdp(0));
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    drive_wr(2'b01, 5'd5, 64'hDEAD_BEEF, 5'd0, '0);
    set_rd(0, 5'd5);
    #1;
    checks++;
    if (rdp(0) !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rdp(0));
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdp(0) !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_stored: got %h expected deadbeef", rdp(0));
    end
  endtask

  task automatic test_collision();
    drive_wr(2'b11, 5'd9, 64'h11, 5'd9, 64'h22);
    set_rd(1, 5'd9);
    #1;
    checks++;
    if (rdp(1) !== 64'h22) begin
      errors++; $display("FAIL collide_bypass: got %h expected 22", rdp(1));
    end
    tick();
    idle();
    #1;
    checks++;
    if (wr_collide !== 1'b1) begin
      errors++; $display("FAIL collide_flag: got %b expected 1", wr_collide);
    end
    checks++;
    if (rdp(1) !== 64'h22) begin
      errors++; $display("FAIL collide_stored: got %h expected 22", rdp(1));
    end
    tick();
    checks++;
    if (wr_collide !== 1'b0) begin
      errors++; $display("FAIL collide_pulse_end: got %b expected 0", wr_collide);
    end
    drive_wr(2'b11, 5'd0, 64'h11, 5'd0, 64'h22);
    set_rd(1, 5'd0);
    #1;
    checks++;
    if (rdp(1) !== '0) begin
      errors++; $display("FAIL collide_x0_read: got %h expected 0", rdp(1));
    end
    tick();
    idle();
    checks++;
    if (wr_collide !== 1'b0) begin
      errors++; $display("FAIL collide_x0_flag: got %b expected 0", wr_collide);
    end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    tick();
    idle();
    set_rd(1, 5'd4);
    #1;
    checks++;
    if (busy_vec[4] !== 1'b1) begin
      errors++; $display("FAIL sb_set: got %b expected 1", busy_vec[4]);
    end
    checks++;
    if (rd_busy[1] !== 1'b1) begin
      errors++; $display("FAIL sb_rd_busy: got %b expected 1", rd_busy[1]);
    end
    drive_wr(2'b01, 5'd4, 64'h44, 5'd0, '0);
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0) begin
      errors++; $display("FAIL sb_rd_busy_bypass: got %b expected 0", rd_busy[1]);
    end
    tick();
    idle();
    checks++;
    if (busy_vec[4] !== 1'b0) begin
      errors++; $display("FAIL sb_clear: got %b expected 0", busy_vec[4]);
    end
  endtask

  task automatic test_set_wins();
    issue_valid = 1'b1;
    issue_rd    = 5'd6;
    tick();
    drive_wr(2'b10, 5'd0, '0, 5'd6, 64'h66);
    tick();
    idle();
    checks++;
    if (busy_vec[6] !== 1'b1) begin
      errors++; $display("FAIL set_wins: got %b expected 1", busy_vec[6]);
    end
    drive_wr(2'b01, 5'd0, 64'hFF, 5'd0, '0);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    tick();
    idle();
    set_rd(0, 5'd0);
    #1;
    checks++;
    if (rdp(0) !== '0) begin
      errors++; $display("FAIL x0_read: got %h expected 0", rdp(0));
    end
    checks++;
    if (busy_vec[0] !== 1'b0) begin
      errors++; $display("FAIL x0_busy: got %b expected 0", busy_vec[0]);
    end
  endtask

  task automatic test_async_reset();
    issue_valid = 1'b1;
    issue_rd    = 5'd2;
    drive_wr(2'b11, 5'd10, 64'h54, 5'd10, 64'h55);
    tick();
    idle();
    set_rd(0, 5'd10);
    #1;
    checks++;
    if (busy_vec[2] !== 1'b1 || wr_collide !== 1'b1 || rdp(0) !== 64'h55) begin
      errors++;
      $display("FAIL arst_pre: got busy2=%b coll=%b x10=%h expected 1 1 55",
               busy_vec[2], wr_collide, rdp(0));
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy_vec !== '0) begin
      errors++; $display("FAIL arst_busy: got %h expected 0", busy_vec);
    end
    checks++;
    if (wr_collide !== 1'b0) begin
      errors++; $display("FAIL arst_collide: got %b expected 0", wr_collide);
    end
    checks++;
    if (rdp(0) !== '0) begin
      errors++; $display("FAIL arst_x10: got %h expected 0", rdp(0));
    end
    // A write presented across an edge while in reset must not land.
    drive_wr(2'b01, 5'd11, 64'h77, 5'd0, '0);
    tick();
    idle();
    set_rd(0, 5'd11);
    #1;
    checks++;
    if (rdp(0) !== '0) begin
      errors++; $display("FAIL arst_no_write: got %h expected 0", rdp(0));
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 400; n++) begin
      we          = 2'($urandom);
      // Narrow address range half of the time to provoke collisions and bypasses.
      if ($urandom_range(0, 1) == 0) wa = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      else                           wa = 10'($urandom);
      wd          = {$urandom, $urandom, $urandom, $urandom};
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      for (int k = 0; k < NRD; k++) begin
        a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        set_rd(k, a);
      end
      #2;
      for (int k = 0; k < NRD; k++) begin
        a = rd_addr[k*AW +: AW];
        checks++;
        if (rdp(k) !== m_read(a)) begin
          errors++;
          $display("FAIL rand_rd_data[%0d] x%0d: got %h expected %h", k, a, rdp(k), m_read(a));
        end
        checks++;
        if (rd_busy[k] !== m_rbusy(a)) begin
          errors++;
          $display("FAIL rand_rd_busy[%0d] x%0d: got %b expected %b", k, a, rd_busy[k], m_rbusy(a));
        end
      end
      tick();
      checks++;
      if (busy_vec !== m_busy_vec()) begin
        errors++; $display("FAIL rand_busy_vec: got %h expected %h", busy_vec, m_busy_vec());
      end
      checks++;
      if (wr_collide !== m_coll) begin
        errors++; $display("FAIL rand_collide: got %b expected %b", wr_collide, m_coll);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined core. It replaces the single-write, two-read SEQ register file and adds:
- NRD read ports with same-cycle write-to-read bypass
- two write ports
- a per-register busy scoreboard for hazard detection
- a registered write-collision flag

It sits between decode (reads, issue) and writeback (writes).

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero
NRD, 2, number of read ports (1..4)
AW, $clog2(NREGS), address width (localparam, derived; not overridable)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr  input  NRD*AW  packed read addresses, port k at [k*AW +: AW]
rd_data  output  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
rd_busy  output  NRD  per read port: addressed register has a pending producer
we  input  2  write enables, bit j for write port j
wa  input  2*AW  packed write addresses
wd  input  2*XLEN  packed write data
issue_valid  input  1  decode issues an instruction that will write issue_rd
issue_rd  input  AW  destination register of issued instruction
busy_vec  output  NREGS  registered scoreboard, bit i = register i pending
wr_collide  output  1  registered pulse: both write ports hit the same nonzero register last cycle

Behaviour:
Reset and register 0:
- rst_n low, asynchronous: all registers = 0, busy_vec = 0, wr_collide = 0.
- The optional feature below overrides the register reset values.
- Register 0: reads always return 0, rd_busy bit always 0, busy_vec[0] always 0.
- Writes to register 0 are ignored and never set wr_collide.

Write ports:
- On rising edge, port j writes wd[j] to wa[j] when we[j]=1 and wa[j]!=0.
- Both ports, same nonzero address: port 1 data stored, port 0 dropped, wr_collide = 1 for exactly the next cycle. Otherwise wr_collide = 0.

Read ports:
- Combinational, zero latency.
- Priority for port k: addr==0 -> 0; else write port 1 match (we[1] && wa[1]==rd_addr) -> wd[1]; else write port 0 match -> wd[0]; else stored value.
- Bypass means decode sees a same-cycle writeback without a bubble.

Scoreboard, per register r != 0, next busy[r]:
- issue_valid && issue_rd==r -> 1. Set wins over a same-cycle clear, because the new producer supersedes the old one.
- else any enabled write port to r -> 0.
- else hold.
- rd_busy[k] = busy_vec[rd_addr_k] AND NOT (same-cycle enabled write to rd_addr_k). Bypassed data is valid, so the port is not busy.
- issue_valid with issue_rd=0: no effect.

Reset mid-operation:
- Deassert/assert at any time: state cleared immediately.
- No partial write completes in the cycle rst_n is low.

Simulation-only:
- $display of each committed write, with register index and hex data.
- Suppress under SYNTHESIS.

Optional Feature:
Macro REGFILE_TEST_INIT_EN:
- Defined: reset loads register i with value i for i=1..7 (zero-extended to XLEN). Registers 8..NREGS-1 load 0. This applies both at initial and on every rst_n assertion.
- Undefined: all registers reset to 0.
- Scoreboard and wr_collide reset are identical in both builds.

Test Plan:
- Reset, REGFILE_TEST_INIT_EN defined; read x3, x7, x8 -> 3, 7, 0. Undefined build -> 0, 0, 0.
- we=01, wa0=5, wd0=0xDEAD_BEEF; read port 0 addr 5 same cycle -> 0xDEADBEEF (bypass). Next cycle without write -> 0xDEADBEEF.
- we=11, wa0=wa1=9, wd0=0x11, wd1=0x22 -> same-cycle read 0x22; stored 0x22; wr_collide=1 next cycle only. Same case with address 0 -> no write, wr_collide=0.
- issue_valid, issue_rd=4 -> busy_vec[4]=1 next cycle; rd_busy=1 on port reading x4. Write x4 via port 0 -> rd_busy=0 that cycle, busy_vec[4]=0 next cycle.
- Same cycle: issue_rd=6 and write to x6 while busy -> busy_vec[6] remains 1. Write x0=0xFF -> x0 reads 0, busy_vec[0]=0.
- Set busy on x2 and write x10=0x55, then pulse rst_n low mid-cycle -> busy_vec=0, x10=0, wr_collide=0 immediately (asynchronous).
